// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fa cell plus a registered carry, LSB first.
// Operands are captured on start; the result and carry land together with a one-cycle done pulse.

module fa (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);
    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_next;
    logic             c_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum, fa_co;

    fa u_fa (
        .a        (a_sr[0]),
        .b        (b_sr[0]),
        .carry_in (c_q),
        .sum      (fa_sum),
        .carry_out(fa_co)
    );

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no empty slice.
    always_comb begin
        s_next            = s_sr >> 1;
        s_next[WIDTH-1]   = fa_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            s_sr      <= '0;
            c_q       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        c_q   <= carry_in;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    s_sr <= s_next;
                    c_q  <= fa_co;
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum       <= s_next;
                        carry_out <= fa_co;
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8, 1 and 32 instances share one stimulus; an arithmetic
// model predicts busy/done/sum/carry_out every cycle, plus directed literal checks on WIDTH=8.

module tb_serial_adder;
    localparam int NI = 3;
    localparam int WS [NI] = '{8, 1, 32};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a_in, b_in;
    logic        cin;

    logic [NI-1:0] busy_v, done_v, co_v;
    logic [31:0]   sum_v [NI];
    logic [7:0]    s8;
    logic [0:0]    s1;
    logic [31:0]   s32;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start), .a(a_in[7:0]), .b(b_in[7:0]), .carry_in(cin),
        .busy(busy_v[0]), .done(done_v[0]), .sum(s8), .carry_out(co_v[0])
    );
    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .a(a_in[0:0]), .b(b_in[0:0]), .carry_in(cin),
        .busy(busy_v[1]), .done(done_v[1]), .sum(s1), .carry_out(co_v[1])
    );
    serial_adder #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .start(start), .a(a_in), .b(b_in), .carry_in(cin),
        .busy(busy_v[2]), .done(done_v[2]), .sum(s32), .carry_out(co_v[2])
    );

    assign sum_v[0] = {24'd0, s8};
    assign sum_v[1] = {31'd0, s1};
    assign sum_v[2] = s32;

    // Model: an accepted start owns the adder for WIDTH+1 cycles (WIDTH busy, then one done).
    int          left [NI];
    logic [63:0] pend [NI];
    logic [63:0] res  [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic [63:0] m;
            m = (64'd1 << WS[i]) - 64'd1;
            if (rst) begin
                left[i] = 0;
                res[i]  = '0;
            end else if (left[i] == 0) begin
                if (start) begin
                    left[i] = WS[i] + 1;
                    pend[i] = ({32'd0, a_in} & m) + ({32'd0, b_in} & m) + {63'd0, cin};
                end
            end else begin
                left[i] = left[i] - 1;
                if (left[i] == 1) res[i] = pend[i];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < NI; i++) begin
                logic [63:0] m;
                m = (64'd1 << WS[i]) - 64'd1;
                chk($sformatf("busy_w%0d", WS[i]), {63'd0, busy_v[i]}, {63'd0, left[i] >= 2});
                chk($sformatf("done_w%0d", WS[i]), {63'd0, done_v[i]}, {63'd0, left[i] == 1});
                chk($sformatf("sum_w%0d", WS[i]), {32'd0, sum_v[i]}, res[i] & m);
                chk($sformatf("cout_w%0d", WS[i]), {63'd0, co_v[i]}, (res[i] >> WS[i]) & 64'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single start pulse on the WIDTH=8 instance; checks latency and literal result.
    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic c,
                         input logic [7:0] es, input logic ec, input string name);
        int lat;
        tick();
        a_in = {24'd0, x}; b_in = {24'd0, y}; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done_v[0] && lat < 20) begin
            tick();
            lat++;
        end
        chk({name, "_lat"}, lat, 8);
        chk({name, "_sum"}, {56'd0, s8}, {56'd0, es});
        chk({name, "_co"}, {63'd0, co_v[0]}, {63'd0, ec});
    endtask

    initial begin
        int ndone, last, cyc;
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        tick();
        tick();
        chk("rst_busy", {61'd0, busy_v}, 64'd0);
        chk("rst_done", {61'd0, done_v}, 64'd0);
        chk("rst_sum8", {56'd0, s8}, 64'd0);
        chk("rst_co", {61'd0, co_v}, 64'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        do_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, "t1");
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2a");
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t2b");

        // Second start during RUN is ignored; operand changes have no effect.
        tick();
        a_in = 32'h10; b_in = 32'h20; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a_in = 32'hAA; b_in = 32'h55; start = 1'b1;
        tick();
        start = 1'b0; a_in = 32'hFF; b_in = 32'hFF;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done_v[0]) begin
                ndone++;
                chk("t3_sum", {56'd0, s8}, 64'h30);
                chk("t3_co", {63'd0, co_v[0]}, 64'd0);
            end
            tick();
        end
        chk("t3_ndone", ndone, 1);

        // Reset mid-RUN aborts with no done pulse.
        repeat (30) tick();
        a_in = 32'h0F; b_in = 32'h0F; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_busy", {63'd0, busy_v[0]}, 64'd0);
        chk("t4_done", {63'd0, done_v[0]}, 64'd0);
        chk("t4_sum", {56'd0, s8}, 64'd0);
        chk("t4_co", {63'd0, co_v[0]}, 64'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_v[0]) ndone++;
            tick();
        end
        chk("t4_nodone", ndone, 0);
        do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "t4b");

        // start held high: one result every WIDTH+2 cycles.
        repeat (40) tick();
        a_in = 32'h80; b_in = 32'h80; cin = 1'b0; start = 1'b1;
        ndone = 0; last = -1;
        for (cyc = 0; cyc < 50; cyc++) begin
            tick();
            if (done_v[0]) begin
                if (last >= 0) chk("t5_spacing", cyc - last, 10);
                chk("t5_sum", {56'd0, s8}, 64'd0);
                chk("t5_co", {63'd0, co_v[0]}, 64'd1);
                last = cyc;
                ndone++;
            end
        end
        chk("t5_ndone", ndone, 5);
        start = 1'b0;
        repeat (40) tick();

        // Random sweep; the model checks every cycle for all three widths.
        for (int i = 0; i < 35000; i++) begin
            a_in  = $urandom;
            b_in  = $urandom;
            cin   = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 15) != 0);
            rst   = ($urandom_range(0, 2999) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
